// File: rtl/hid_pkg.sv
// Shared types and constants for the Bluetooth HID packet decoder.
//   state_t   : framing FSM states (StGetCk exists only in checksum builds)
//   ERR_*     : err_code encodings
//   HDR_MARK  : value of byte[7:6] that marks a header byte
//   CMD_*     : command id values
package hid_pkg;

  typedef enum logic [1:0] {StIdle, StGetX, StGetY, StGetCk} state_t;

  localparam logic [2:0] ERR_RESYNC   = 3'd0;
  localparam logic [2:0] ERR_RANGE    = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_CHECKSUM = 3'd4;

  localparam logic [1:0] HDR_MARK = 2'b11;

  localparam logic [2:0] CMD_MOVE = 3'd1;

endpackage

// File: rtl/hid_cmd_fifo.sv
// Synchronous command FIFO with a registered first-word-fall-through head.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request; ignored when full unless a pop happens in the same cycle
//   full       : storage holds DEPTH entries
//   ready      : consumer accepts the head when valid && ready
//   valid/rdata: registered head of the queue
//   count      : entries stored (including the one shown at the head)
// The head register mirrors the oldest entry that was already stored before the current edge,
// so a push into an empty FIFO becomes visible one cycle after it is written.
module hid_cmd_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic             pop, wr_en, valid_d;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pop      = valid && ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    wr_en    = push && (!full || pop);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    valid_d  = (count_q - CW'(pop)) != '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid    <= 1'b0;
      rdata    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_q + CW'(wr_en) - CW'(pop);
      valid    <= valid_d;
      rdata    <= valid_d ? mem[rd_ptr_d] : '0;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bt_packet_decoder.sv
// Frames UART bytes into paint commands (header + 0 or 2 coordinate bytes), checks each frame,
// times out stalled frames and queues decoded commands in a FIFO.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_valid, rx_byte     : one-cycle received-byte strobe from uart_rx
//   cmd_valid, cmd_ready  : FIFO head handshake
//   cmd_id, cmd_x, cmd_y  : FIFO head contents (x/y are 0 for argless commands)
//   fifo_count            : entries queued
//   err_pulse, err_code   : registered one-cycle error strobe and cause
// Optional feature: define BT_CHECKSUM_EN to require a trailing checksum byte on every frame.
module bt_packet_decoder
  import hid_pkg::*;
#(
  parameter int unsigned COORD_W        = 6,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 52_083,
  parameter logic [7:0]  ARGLESS_MASK   = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [2:0]                    cmd_id,
  output logic [COORD_W-1:0]            cmd_x,
  output logic [COORD_W-1:0]            cmd_y,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_pulse,
  output logic [2:0]                    err_code
);

  localparam int unsigned DW = 3 + 2 * COORD_W;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t               state_q;
  logic [2:0]           id_q;
  logic [COORD_W-1:0]   x_q;
  logic [TW-1:0]        tmo_q;
`ifdef BT_CHECKSUM_EN
  logic [COORD_W-1:0]   y_q;
  logic [7:0]           ck_q;
`endif

  logic               rx_hdr, rx_pay, in_frame, range_bad, hdr_argless;
  logic [2:0]         hdr_id;
  logic [COORD_W-1:0] pay_val;
  logic               e_resync, e_range, e_timeout, e_ovf, e_ck;
  logic               push, fifo_full, err_any;
  logic [DW-1:0]      push_data, head_data;
  logic [2:0]         err_sel;

  always_comb begin
    rx_hdr      = rx_valid && (rx_byte[7:6] == HDR_MARK);
    rx_pay      = rx_valid && (rx_byte[7:6] != HDR_MARK);
    hdr_id      = rx_byte[2:0];
    hdr_argless = ARGLESS_MASK[hdr_id];
    pay_val     = rx_byte[COORD_W-1:0];
    range_bad   = |rx_byte[7:COORD_W];
    in_frame    = (state_q != StIdle);

    e_resync  = rx_hdr && in_frame;
    e_range   = rx_pay && ((state_q == StGetX) || (state_q == StGetY)) && range_bad;
    // A byte arriving in the expiry cycle restarts the window instead.
    e_timeout = !rx_valid && in_frame && (tmo_q == TMO_LAST);

`ifdef BT_CHECKSUM_EN
    e_ck      = rx_pay && (state_q == StGetCk) && (rx_byte != {2'b00, ck_q[5:0]});
    push      = rx_pay && (state_q == StGetCk) && !e_ck;
    push_data = {id_q, x_q, y_q};
`else
    e_ck      = 1'b0;
    push      = (rx_hdr && hdr_argless) || (rx_pay && (state_q == StGetY) && !range_bad);
    push_data = rx_hdr ? {hdr_id, {(2 * COORD_W){1'b0}}} : {id_q, x_q, pay_val};
`endif

    e_ovf = push && fifo_full && !(cmd_valid && cmd_ready);

    err_any = 1'b1;
    if (e_ck)           err_sel = ERR_CHECKSUM;
    else if (e_range)   err_sel = ERR_RANGE;
    else if (e_resync)  err_sel = ERR_RESYNC;
    else if (e_timeout) err_sel = ERR_TIMEOUT;
    else if (e_ovf)     err_sel = ERR_OVERFLOW;
    else begin
      err_any = 1'b0;
      err_sel = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      id_q      <= '0;
      x_q       <= '0;
      tmo_q     <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
`ifdef BT_CHECKSUM_EN
      y_q       <= '0;
      ck_q      <= '0;
`endif
    end else begin
      err_pulse <= err_any;
      err_code  <= err_sel;

      if (rx_valid || !in_frame || e_timeout) tmo_q <= '0;
      else                                    tmo_q <= tmo_q + TW'(1);

      if (rx_hdr) begin
        // Any header (re)starts a frame, discarding whatever was partial.
        id_q <= hdr_id;
        x_q  <= '0;
`ifdef BT_CHECKSUM_EN
        y_q     <= '0;
        ck_q    <= rx_byte;
        state_q <= hdr_argless ? StGetCk : StGetX;
`else
        state_q <= hdr_argless ? StIdle : StGetX;
`endif
      end else if (rx_pay) begin
        case (state_q)
          StGetX: begin
            if (range_bad) state_q <= StIdle;
            else begin
              x_q     <= pay_val;
              state_q <= StGetY;
`ifdef BT_CHECKSUM_EN
              ck_q    <= ck_q ^ rx_byte;
`endif
            end
          end
          StGetY: begin
`ifdef BT_CHECKSUM_EN
            if (range_bad) state_q <= StIdle;
            else begin
              y_q     <= pay_val;
              ck_q    <= ck_q ^ rx_byte;
              state_q <= StGetCk;
            end
`else
            state_q <= StIdle;
`endif
          end
          default: state_q <= StIdle;  // idle payloads are discarded; GET_CK always ends
        endcase
      end else if (e_timeout) begin
        state_q <= StIdle;
      end
    end
  end

  hid_cmd_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .full  (fifo_full),
    .ready (cmd_ready),
    .valid (cmd_valid),
    .rdata (head_data),
    .count (fifo_count)
  );

  assign cmd_id = head_data[DW-1 -: 3];
  assign cmd_x  = head_data[2*COORD_W-1 -: COORD_W];
  assign cmd_y  = head_data[COORD_W-1:0];

endmodule

// File: tb/tb_bt_packet_decoder.sv
// Directed self-checking bench for bt_packet_decoder (COORD_W=6, FIFO_DEPTH=4,
// TIMEOUT_CYCLES=40, ARGLESS_MASK=8'h04). Inputs change 2 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_bt_packet_decoder;

  localparam int CW = 6;
  localparam int FD = 4;
  localparam int TO = 40;

  logic          clk, rst_n, rx_valid, cmd_ready;
  logic [7:0]    rx_byte;
  logic          cmd_valid, err_pulse;
  logic [2:0]    cmd_id, err_code;
  logic [CW-1:0] cmd_x, cmd_y;
  logic [$clog2(FD):0] fifo_count;

  int n_err = 0;
  int n_chk = 0;
  int err_seen = 0;
  logic [2:0]  last_code = '0;
  logic [14:0] got_q[$];

  bt_packet_decoder #(
    .COORD_W        (CW),
    .FIFO_DEPTH     (FD),
    .TIMEOUT_CYCLES (TO),
    .ARGLESS_MASK   (8'h04)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .fifo_count (fifo_count),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log error strobes and accepted commands.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_pulse) begin
        err_seen  = err_seen + 1;
        last_code = err_code;
      end
      if (cmd_valid && cmd_ready) got_q.push_back({cmd_id, cmd_x, cmd_y});
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #2;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log;
    err_seen = 0;
    got_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
    #12;
    n_chk++;
    if ({cmd_valid, cmd_id, cmd_x, cmd_y, err_pulse, err_code} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b id=%0d x=%0d y=%0d ep=%b ec=%0d want all 0",
               cmd_valid, cmd_id, cmd_x, cmd_y, err_pulse, err_code);
    end
    n_chk++;
    if (fifo_count !== 0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    logic [14:0] exp;
    exp = {3'd1, 6'd35, 6'd50};
    clear_log();
    cmd_ready = 1'b1;
    send(8'hC1);
    send(8'h23);
    @(posedge clk); #2; rx_valid = 1'b1; rx_byte = 8'h32;
    @(posedge clk); #2; rx_valid = 1'b0; rx_byte = 8'h00;
    @(negedge clk);
    n_chk++;
    if (cmd_valid !== 1'b0 || fifo_count !== 1) begin
      n_err++;
      $display("FAIL basic_lat1: got valid=%b count=%0d want valid=0 count=1", cmd_valid, fifo_count);
    end
    @(negedge clk);
    n_chk++;
    if (cmd_valid !== 1'b1 || {cmd_id, cmd_x, cmd_y} !== exp) begin
      n_err++;
      $display("FAIL basic_lat2: got valid=%b id=%0d x=%0d y=%0d want valid=1 id=1 x=35 y=50",
               cmd_valid, cmd_id, cmd_x, cmd_y);
    end
    idle(3);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== exp || err_seen != 0) begin
      n_err++;
      $display("FAIL basic_out: got n=%0d errs=%0d want one cmd, no errors", got_q.size(), err_seen);
    end
  endtask

  task automatic test_argless;
    clear_log();
    send(8'hC2);
    send(8'hC1); send(8'h05); send(8'h06);
    idle(4);
    n_chk++;
    if (got_q.size() != 2 || err_seen != 0) begin
      n_err++; $display("FAIL argless_n: got n=%0d errs=%0d want 2 cmds 0 errs", got_q.size(), err_seen);
    end else begin
      n_chk++;
      if (got_q[0] !== {3'd2, 6'd0, 6'd0}) begin
        n_err++; $display("FAIL argless_c0: got %h want %h", got_q[0], {3'd2, 6'd0, 6'd0});
      end
      n_chk++;
      if (got_q[1] !== {3'd1, 6'd5, 6'd6}) begin
        n_err++; $display("FAIL argless_c1: got %h want %h", got_q[1], {3'd1, 6'd5, 6'd6});
      end
    end
  endtask

  task automatic test_resync;
    clear_log();
    send(8'hC1); send(8'h23); send(8'hC1); send(8'h01); send(8'h02);
    idle(4);
    n_chk++;
    if (err_seen != 1 || last_code !== 3'd0) begin
      n_err++; $display("FAIL resync_err: got n=%0d code=%0d want 1 code 0", err_seen, last_code);
    end
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 6'd1, 6'd2}) begin
      n_err++; $display("FAIL resync_cmd: got n=%0d want one cmd id1 x1 y2", got_q.size());
    end
  endtask

  task automatic test_range;
    clear_log();
    send(8'hC1); send(8'h40);
    idle(3);
    n_chk++;
    if (err_seen != 1 || last_code !== 3'd1 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL range_err: got n=%0d code=%0d cmds=%0d want 1 code 1 no cmd",
               err_seen, last_code, got_q.size());
    end
    send(8'hC1); send(8'h02); send(8'h03);
    idle(4);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 6'd2, 6'd3} || err_seen != 1) begin
      n_err++; $display("FAIL range_recover: got n=%0d errs=%0d want one cmd x2 y3", got_q.size(), err_seen);
    end
  endtask

  task automatic test_timeout;
    clear_log();
    send(8'hC1); send(8'h23);
    idle(TO - 4);
    n_chk++;
    if (err_seen != 0) begin
      n_err++; $display("FAIL timeout_early: got %0d errors want 0", err_seen);
    end
    idle(8);
    n_chk++;
    if (err_seen != 1 || last_code !== 3'd2) begin
      n_err++; $display("FAIL timeout_err: got n=%0d code=%0d want 1 code 2", err_seen, last_code);
    end
    send(8'h01); send(8'h02);
    idle(4);
    n_chk++;
    if (got_q.size() != 0 || err_seen != 1) begin
      n_err++; $display("FAIL timeout_idle: got cmds=%0d errs=%0d want 0 cmds 1 err", got_q.size(), err_seen);
    end
  endtask

  task automatic test_overflow;
    clear_log();
    cmd_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(8'hC1); send(8'(k)); send(8'h01);
    end
    idle(2);
    n_chk++;
    if (fifo_count !== 4 || err_seen != 0) begin
      n_err++; $display("FAIL ovf_fill: got count=%0d errs=%0d want 4 0", fifo_count, err_seen);
    end
    send(8'hC1); send(8'h05); send(8'h01);
    idle(2);
    n_chk++;
    if (fifo_count !== 4 || err_seen != 1 || last_code !== 3'd3) begin
      n_err++;
      $display("FAIL ovf_err: got count=%0d n=%0d code=%0d want 4 1 3", fifo_count, err_seen, last_code);
    end
    n_chk++;
    if (cmd_valid !== 1'b1 || {cmd_id, cmd_x, cmd_y} !== {3'd1, 6'd1, 6'd1}) begin
      n_err++; $display("FAIL ovf_head: got v=%b x=%0d y=%0d want v=1 x=1 y=1", cmd_valid, cmd_x, cmd_y);
    end
    // Final byte of a frame lands on the same edge as the first pop.
    send(8'hC1); send(8'h06);
    @(posedge clk); #2; rx_valid = 1'b1; rx_byte = 8'h07; cmd_ready = 1'b1;
    @(posedge clk); #2; rx_valid = 1'b0; rx_byte = 8'h00;
    @(negedge clk);
    n_chk++;
    if (fifo_count !== 4) begin
      n_err++; $display("FAIL ovf_swap_count: got %0d want 4", fifo_count);
    end
    idle(10);
    n_chk++;
    if (got_q.size() != 5 || err_seen != 1 || fifo_count !== 0 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_drain: got n=%0d errs=%0d count=%0d v=%b want 5 1 0 0",
               got_q.size(), err_seen, fifo_count, cmd_valid);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got_q[k] !== {3'd1, 6'(k + 1), 6'd1}) begin
          n_err++; $display("FAIL ovf_order%0d: got %h want %h", k, got_q[k], {3'd1, 6'(k + 1), 6'd1});
        end
      end
      n_chk++;
      if (got_q[4] !== {3'd1, 6'd6, 6'd7}) begin
        n_err++; $display("FAIL ovf_swap_cmd: got %h want %h", got_q[4], {3'd1, 6'd6, 6'd7});
      end
    end
  endtask

  task automatic test_reset_midframe;
    clear_log();
    cmd_ready = 1'b0;
    send(8'hC1); send(8'h0A); send(8'h0B);
    send(8'hC1); send(8'h23);
    idle(1);
    n_chk++;
    if (fifo_count !== 1) begin
      n_err++; $display("FAIL rst_pre: got count=%0d want 1", fifo_count);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cmd_valid, cmd_id, cmd_x, cmd_y, err_pulse, err_code} !== '0 || fifo_count !== 0) begin
      n_err++;
      $display("FAIL rst_async: got v=%b id=%0d x=%0d y=%0d count=%0d want all 0",
               cmd_valid, cmd_id, cmd_x, cmd_y, fifo_count);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    send(8'h01); send(8'h02);
    idle(3);
    n_chk++;
    if (fifo_count !== 0 || err_seen != 0) begin
      n_err++; $display("FAIL rst_discard: got count=%0d errs=%0d want 0 0", fifo_count, err_seen);
    end
    cmd_ready = 1'b1;
    send(8'hC1); send(8'h03); send(8'h04);
    idle(4);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 6'd3, 6'd4}) begin
      n_err++; $display("FAIL rst_after: got n=%0d want one cmd x3 y4", got_q.size());
    end
  endtask

`ifdef BT_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] ck;
    ck = (8'hC1 ^ 8'h23 ^ 8'h32) & 8'h3F;
    clear_log();
    cmd_ready = 1'b1;
    send(8'hC1); send(8'h23); send(8'h32); send(ck);
    idle(4);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 6'd35, 6'd50} || err_seen != 0) begin
      n_err++; $display("FAIL ck_good: got n=%0d errs=%0d want one cmd", got_q.size(), err_seen);
    end
    send(8'hC1); send(8'h23); send(8'h32); send(ck ^ 8'h01);
    idle(4);
    n_chk++;
    if (got_q.size() != 1 || err_seen != 1 || last_code !== 3'd4) begin
      n_err++;
      $display("FAIL ck_bad: got n=%0d errs=%0d code=%0d want 1 1 4", got_q.size(), err_seen, last_code);
    end
    send(8'hC2); send(8'h02);
    idle(4);
    n_chk++;
    if (got_q.size() != 2 || got_q[1] !== {3'd2, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL ck_argless: got n=%0d want argless id2", got_q.size());
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef BT_CHECKSUM_EN
    test_checksum();
`else
    test_basic();
    test_argless();
    test_resync();
    test_range();
    test_timeout();
    test_overflow();
    test_reset_midframe();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
